// File: rtl/enc_event_pkg.sv
// enc_event_pkg
//   Shared sizing for the encoder event FIFO: FIFO depth, code/pointer/level
//   widths, drop counter width and saturation value, and the packed sample
//   type {v, code} carried through the capture/history stages.
package enc_event_pkg;

  localparam int FIFO_DEPTH  = 4;
  localparam int CODE_W      = 2;
  localparam int PTR_W       = 2;
  localparam int LVL_W       = 3;
  localparam int DROP_W      = 4;
  localparam int DROP_MAX    = 15;

  // Sample = {valid, code}; also the width of the optional input synchronizer.
  localparam int SMP_W       = 1 + CODE_W;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic              v;
    logic [CODE_W-1:0] code;
  } enc_sample_t;

endpackage

// File: rtl/enc_event_sync.sv
// enc_event_sync
//   Multi-flop synchronizer for the raw encoder sample {v, q1, q0}.
//   Ports:
//     clk, rst_n : clock, async active-low reset (clears every stage)
//     d_i        : asynchronous input bits
//     q_o        : synchronized bits, STAGES cycles later
module enc_event_sync
  import enc_event_pkg::*;
#(
  parameter int W      = SMP_W,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // stg_q[0] is the first flop after the input, stg_q[STAGES-1] the output.
  logic [STAGES-1:0][W-1:0] stg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/enc_event_fifo.sv
// enc_event_fifo
//   Turns the output of a 4-to-2 priority encoder into a stream of change
//   events and buffers them in a 4-entry FIFO.
//   An event is a rising valid, or a code change while valid stays high.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     enc_q0/enc_q1/enc_v : encoder code bits and valid
//     out_valid/out_code  : FIFO head (code reads 00 when empty)
//     out_ready           : consumer pops the head when out_valid is high
//     level               : stored entries 0..4
//     ovf, drop_cnt       : sticky overflow flag, saturating drop count
//     ovf_clr             : synchronous clear of ovf/drop_cnt (a same-edge
//                           drop still wins)
//   Build option: define ENC_EVENT_SYNC_EN to put a 2-flop synchronizer on
//   the encoder inputs ahead of the capture stage (+2 cycles latency).
module enc_event_fifo
  import enc_event_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_q0,
  input  logic              enc_q1,
  input  logic              enc_v,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              ovf_clr
);

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [DROP_W-1:0] DROP_SAT = DROP_W'(DROP_MAX);

  // ---------------------------------------------------------------- input
  logic [SMP_W-1:0] smp_raw, smp_in;
  assign smp_raw = {enc_v, enc_q1, enc_q0};

`ifdef ENC_EVENT_SYNC_EN
  enc_event_sync #(.W(SMP_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (smp_raw),
    .q_o   (smp_in)
  );
`else
  assign smp_in = smp_raw;
`endif

  // -------------------------------------------- capture r0 / history r1
  enc_sample_t r0_q, r1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q <= '0;
      r1_q <= '0;
    end else begin
      r0_q <= enc_sample_t'(smp_in);
      r1_q <= r0_q;
    end
  end

  // --------------------------------------------------------------- FIFO
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              ev, pop, full, push, drop;

  always_comb begin
    ev   = r0_q.v && (!r1_q.v || (r0_q.code != r1_q.code));
    pop  = (level_q != '0) && out_ready;
    full = (level_q == LVL_FULL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push = ev && (!full || pop);
    drop = ev && full && !pop;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    // Clear first, then let a same-edge drop override it.
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != DROP_SAT) drop_cnt_d = drop_cnt_d + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= r0_q.code;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ------------------------------------------------------------ outputs
  assign out_valid = (level_q != '0);
  assign out_code  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_enc_event_fifo.sv
// tb_enc_event_fifo
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a queue-based reference model of the event FIFO.
module tb_enc_event_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enc_q0 = 1'b0, enc_q1 = 1'b0, enc_v = 1'b0;
  logic       out_ready = 1'b0, ovf_clr = 1'b0;
  logic       out_valid;
  logic [1:0] out_code;
  logic [2:0] level;
  logic       ovf;
  logic [3:0] drop_cnt;

  always #5 clk = ~clk;

  enc_event_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enc_q0    (enc_q0),
    .enc_q1    (enc_q1),
    .enc_v     (enc_v),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  // Extra input delay added by the optional synchronizer.
`ifdef ENC_EVENT_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of stored codes, overflow state, and the history
  // of applied input samples {v,code}; hist[0] is the one applied before the
  // previous edge.
  logic [1:0] mq[$];
  logic       m_ovf;
  int         m_cnt;
  logic [2:0] hist [0:5];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 6; i++) hist[i] = 3'b000;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 2'b00;
    chk({tag, ".valid"}, 8'(out_valid), 8'(mq.size() != 0));
    chk({tag, ".code"},  8'(out_code),  8'(hd));
    chk({tag, ".level"}, 8'(level),     8'(mq.size()));
    chk({tag, ".ovf"},   8'(ovf),       8'(m_ovf));
    chk({tag, ".drop"},  8'(drop_cnt),  8'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, check.
  task automatic step(input logic v, input logic [1:0] c, input logic rdy,
                      input logic clr, input string tag);
    logic [2:0] cur, prv;
    bit         ev;
    enc_v = v; {enc_q1, enc_q0} = c; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    cur = hist[DLY];
    prv = hist[DLY+1];
    ev  = cur[2] && (!prv[2] || (cur[1:0] != prv[1:0]));
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
    if (ev) begin
      if (mq.size() < 4) mq.push_back(cur[1:0]);
      else begin
        m_ovf = 1'b1;
        if (m_cnt < 15) m_cnt++;
      end
    end
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {v, c};
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 8'(out_valid), 8'd0);
    chk({tag, ".rst_code"},  8'(out_code),  8'd0);
    chk({tag, ".rst_level"}, 8'(level),     8'd0);
    chk({tag, ".rst_ovf"},   8'(ovf),       8'd0);
    chk({tag, ".rst_drop"},  8'(drop_cnt),  8'd0);
    m_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic       v;
    logic [1:0] c;
    int         rdy_pct;

    m_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("init.valid", 8'(out_valid), 8'd0);
    chk("init.code",  8'(out_code),  8'd0);
    chk("init.level", 8'(level),     8'd0);
    chk("init.ovf",   8'(ovf),       8'd0);
    chk("init.drop",  8'(drop_cnt),  8'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, "idle");
    step(1'b0, 2'b00, 1'b1, 1'b0, "idle_rdy");

    // v rise with code 10: head appears DLY+1 edges after the capture edge.
    step(1'b1, 2'b10, 1'b0, 1'b0, "rise");
    repeat (DLY) step(1'b1, 2'b10, 1'b0, 1'b0, "rise_wait");
    chk("rise.pre_valid", 8'(out_valid), 8'd0);
    step(1'b1, 2'b10, 1'b0, 1'b0, "rise_push");
    chk("rise.valid", 8'(out_valid), 8'd1);
    chk("rise.code",  8'(out_code),  8'h2);
    chk("rise.level", 8'(level),     8'd1);
    repeat (4) step(1'b1, 2'b10, 1'b0, 1'b0, "hold");
    chk("hold.level", 8'(level), 8'd1);
    step(1'b1, 2'b10, 1'b1, 1'b0, "drain1");

    // Code changes with v held high, then drain one per cycle.
    step(1'b1, 2'b01, 1'b0, 1'b0, "chg01");
    step(1'b1, 2'b11, 1'b0, 1'b0, "chg11");
    step(1'b1, 2'b00, 1'b0, 1'b0, "chg00");
    repeat (DLY + 2) step(1'b1, 2'b00, 1'b0, 1'b0, "chg_hold");
    chk("chg.level", 8'(level),    8'd3);
    chk("chg.head",  8'(out_code), 8'h1);
    repeat (3) step(1'b1, 2'b00, 1'b1, 1'b0, "pop");
    chk("pop.level", 8'(level), 8'd0);

    // Six distinct events with no consumer: 4 stored, 2 dropped.
    step(1'b1, 2'b01, 1'b0, 1'b0, "ov1");
    step(1'b1, 2'b10, 1'b0, 1'b0, "ov2");
    step(1'b1, 2'b11, 1'b0, 1'b0, "ov3");
    step(1'b1, 2'b00, 1'b0, 1'b0, "ov4");
    step(1'b1, 2'b01, 1'b0, 1'b0, "ov5");
    step(1'b1, 2'b10, 1'b0, 1'b0, "ov6");
    repeat (DLY + 2) step(1'b1, 2'b10, 1'b0, 1'b0, "ov_hold");
    chk("ov.level", 8'(level),    8'd4);
    chk("ov.ovf",   8'(ovf),      8'd1);
    chk("ov.drop",  8'(drop_cnt), 8'd2);
    chk("ov.head",  8'(out_code), 8'h1);
    step(1'b1, 2'b10, 1'b0, 1'b1, "ovclr");
    chk("ovclr.ovf",   8'(ovf),      8'd0);
    chk("ovclr.drop",  8'(drop_cnt), 8'd0);
    chk("ovclr.level", 8'(level),    8'd4);

    // Full FIFO, pop and push on the same edge: no drop.
    step(1'b1, 2'b11, 1'b0, 1'b0, "fp_ev");
    repeat (DLY) step(1'b1, 2'b11, 1'b0, 1'b0, "fp_wait");
    step(1'b1, 2'b11, 1'b1, 1'b0, "fp_edge");
    chk("fp.level", 8'(level),    8'd4);
    chk("fp.drop",  8'(drop_cnt), 8'd0);
    step(1'b1, 2'b11, 1'b1, 1'b0, "fp_pop");
    chk("fp.level3", 8'(level), 8'd3);

    // Reset mid-operation with three entries stored.
    pulse_reset("midrst");
    step(1'b1, 2'b11, 1'b0, 1'b0, "post_rst");
    repeat (DLY + 2) step(1'b1, 2'b11, 1'b0, 1'b0, "post_rst_hold");
    chk("post_rst.level", 8'(level), 8'd1);

    // Randomized traffic with varying consumer pressure.
    v = 1'b1; c = 2'b11; rdy_pct = 30;
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) rdy_pct = (rdy_pct == 30) ? 75 : 30;
      v = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) c = 2'($urandom_range(0, 3));
      step(v, c, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 19) == 0), "rnd");
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enc_event_fifo.md
ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

Interface
REQ-001 The block SHALL have exactly one clock and one reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enc_q0  input  1  encoder code bit 0, from the 4-to-2 priority encoder.
REQ-005 enc_q1  input  1  encoder code bit 1.
REQ-006 enc_v  input  1  encoder valid; high when any request line is active.
REQ-007 out_valid  output  1  FIFO head holds an event.
REQ-008 out_code  output  2  head event code {q1,q0}; 2'b00 when empty.
REQ-009 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-010 level  output  3  stored entries, 0..4.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 drop_cnt  output  4  dropped-event count, saturating at 15.
REQ-013 ovf_clr  input  1  synchronous clear of ovf and drop_cnt.

Function
REQ-014 Inputs SHALL be registered into capture stage r0 each cycle; r0 SHALL also be copied to history stage r1 each cycle.
REQ-015 An event SHALL be flagged when r0.v=1 and (r1.v=0 or r0.code!=r1.code); no event while r0.v=0.
REQ-016 A flagged event SHALL push r0.code into a 4-entry circular FIFO on the same edge.
REQ-017 Latency: input change before edge N SHALL give out_valid=1 after edge N+1 when FIFO empty (macro off).
REQ-018 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; read pointer advances mod 4.
REQ-019 out_valid SHALL equal (level!=0); out_code SHALL be head entry, or 2'b00 when level=0.
REQ-020 Push when level=4 and no pop SHALL drop the event, set ovf=1, and increment drop_cnt (saturating at 15).
REQ-021 Push and pop on the same edge with level=4 SHALL accept the push; level stays 4, no drop.
REQ-022 Push and pop on the same edge with level=0 SHALL not occur (out_valid=0); the push completes, level becomes 1.
REQ-023 out_ready while level=0 SHALL have no effect.
REQ-024 ovf_clr=1 SHALL clear ovf and drop_cnt; a drop on the same edge SHALL win (ovf=1, drop_cnt=1).
REQ-025 Pointers SHALL be 2 bits wrapping 3->0; level SHALL be tracked separately to distinguish full/empty.

Reset
REQ-026 rst_n=0 SHALL immediately clear r0, r1, pointers, level, ovf, drop_cnt, and any synchronizer flops.
REQ-027 Reset values: out_valid=0, out_code=2'b00, level=0, ovf=0, drop_cnt=0.
REQ-028 Reset mid-operation SHALL discard all stored entries; first post-reset event requires a fresh v rise or code change against the cleared r1 (v=0).

Configuration
REQ-029 Macro ENC_EVENT_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on enc_q0/enc_q1/enc_v ahead of r0, adding 2 cycles (out_valid after edge N+3).
REQ-030 Without ENC_EVENT_SYNC_EN, inputs SHALL feed r0 directly; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package enc_event_pkg SHALL hold FIFO depth (4), code width (2), pointer width (2), level width (3), drop counter width (4) and drop-counter max (15).
REQ-032 The synchronizer SHALL be a separate sub-module enc_event_sync (3-bit, 2-stage), instantiated only under ENC_EVENT_SYNC_EN.

Verification
REQ-033 Reset release, inputs idle -> out_valid=0, out_code=00, level=0, ovf=0, drop_cnt=0.
REQ-034 enc_v 0->1 with code 10, out_ready=0 -> out_valid=1, out_code=10, level=1 two edges later; holding inputs adds no entries.
REQ-035 enc_v held 1, code 01->11->00 on separate cycles -> three entries 01,11,00 in order; then out_ready=1 -> popped one per cycle, level 3->0.
REQ-036 Six distinct events with out_ready=0 -> level=4, ovf=1, drop_cnt=2, head=first event; ovf_clr pulse -> ovf=0, drop_cnt=0, level still 4.
REQ-037 level=4, out_ready=1 and new event same edge -> level stays 4, drop_cnt unchanged, new code at tail.
REQ-038 rst_n asserted with level=3 -> outputs immediately at reset values; with ENC_EVENT_SYNC_EN, repeat REQ-034 -> out_valid after four edges.
